// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the full-speed USB transmit path.
// Line codes are packed as {dp, dm}.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP_SE0,
        EOP_J
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

// File: rtl/usb_tx_encoder_flex_counter.sv
// Free-running modulo counter with synchronous clear; rollover_flag marks the
// last count before wrapping to zero.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] count_reg;

    assign rollover_flag = (count_reg == rollover_val - ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (count_enable) begin
            count_reg <= rollover_flag ? '0 : count_reg + ONE;
        end
    end

endmodule

// File: rtl/usb_tx_encoder.sv
// Full-speed USB packet transmitter: SYNC prefix, LSB-first serialisation,
// bit stuffing, NRZI line coding and EOP generation onto D+/D-.
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LEN    = 6,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam int EW = $clog2(EOP_SE0_BITS + 1);

    localparam logic [CW-1:0] ROLL_VAL  = CW'(CLKS_PER_BIT);
    localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LEN);
    localparam logic [EW-1:0] SE0_LAST  = EW'(EOP_SE0_BITS - 1);

    tx_state_t   state_reg, state_next;
    logic [7:0]  shift_reg, shift_next;
    logic        shift_last_reg, shift_last_next;
    logic [7:0]  hold_data_reg, hold_data_next;
    logic        hold_last_reg, hold_last_next;
    logic        hold_full_reg, hold_full_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [OW-1:0] ones_reg, ones_next;
    logic [EW-1:0] eop_cnt_reg, eop_cnt_next;
    logic        nrzi_j_reg, nrzi_j_next;
    logic [1:0]  line_reg, line_next;
    logic        active_reg, active_next;
    logic        done_reg, done_next;
    logic        error_reg, error_next;
    logic        err_seen_reg, err_seen_next;

    logic bit_tick;
    logic boundary;
    logic accept;
    logic send_bit;
    logic bit_val;

    flex_counter #(
        .NUM_CNT_BITS(CW)
    ) u_bit_timer (
        .clk          (clk),
        .rst          (rst),
        .clear        (state_reg == IDLE),
        .count_enable (1'b1),
        .rollover_val (ROLL_VAL),
        .rollover_flag(bit_tick)
    );

    assign boundary   = bit_tick && (state_reg != IDLE);
    assign accept     = tx_valid && !hold_full_reg;
    assign tx_ready   = !hold_full_reg;
    assign dplus_out  = line_reg[1];
    assign dminus_out = line_reg[0];
    assign tx_active  = active_reg;
    assign tx_done    = done_reg;
    assign tx_error   = error_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            shift_last_reg <= 1'b0;
            hold_data_reg  <= '0;
            hold_last_reg  <= 1'b0;
            hold_full_reg  <= 1'b0;
            bit_idx_reg    <= '0;
            ones_reg       <= '0;
            eop_cnt_reg    <= '0;
            nrzi_j_reg     <= 1'b1;
            line_reg       <= LINE_J;
            active_reg     <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            err_seen_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            shift_last_reg <= shift_last_next;
            hold_data_reg  <= hold_data_next;
            hold_last_reg  <= hold_last_next;
            hold_full_reg  <= hold_full_next;
            bit_idx_reg    <= bit_idx_next;
            ones_reg       <= ones_next;
            eop_cnt_reg    <= eop_cnt_next;
            nrzi_j_reg     <= nrzi_j_next;
            line_reg       <= line_next;
            active_reg     <= active_next;
            done_reg       <= done_next;
            error_reg      <= error_next;
            err_seen_reg   <= err_seen_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        shift_last_next = shift_last_reg;
        hold_data_next  = hold_data_reg;
        hold_last_next  = hold_last_reg;
        hold_full_next  = hold_full_reg;
        bit_idx_next    = bit_idx_reg;
        ones_next       = ones_reg;
        eop_cnt_next    = eop_cnt_reg;
        nrzi_j_next     = nrzi_j_reg;
        line_next       = line_reg;
        active_next     = active_reg;
        done_next       = 1'b0;
        error_next      = 1'b0;
        err_seen_next   = err_seen_reg;
        send_bit        = 1'b0;
        bit_val         = 1'b0;

        if (accept) begin
            hold_data_next = tx_data;
            hold_last_next = tx_last;
            hold_full_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                // A byte held over from the previous EOP starts a packet without a new handshake.
                if (hold_full_reg || accept) begin
                    state_next      = SYNC;
                    shift_next      = SYNC_BYTE;
                    shift_last_next = 1'b0;
                    bit_idx_next    = '0;
                    nrzi_j_next     = SYNC_BYTE[0];
                    ones_next       = SYNC_BYTE[0] ? OW'(1) : '0;
                    line_next       = SYNC_BYTE[0] ? LINE_J : LINE_K;
                    active_next     = 1'b1;
                    err_seen_next   = 1'b0;
                end
            end

            SYNC, DATA: begin
                if (boundary) begin
                    if (ones_reg == STUFF_MAX) begin
                        // Stuffed zero: shift register and bit index stay put.
                        send_bit = 1'b1;
                        bit_val  = 1'b0;
                    end else if (bit_idx_reg != 3'd7) begin
                        shift_next   = shift_reg >> 1;
                        bit_idx_next = bit_idx_reg + 3'd1;
                        send_bit     = 1'b1;
                        bit_val      = shift_reg[1];
                    end else if (state_reg == SYNC || (!shift_last_reg && hold_full_reg)) begin
                        state_next      = DATA;
                        shift_next      = hold_data_reg;
                        shift_last_next = hold_last_reg;
                        hold_full_next  = 1'b0;
                        bit_idx_next    = '0;
                        send_bit        = 1'b1;
                        bit_val         = hold_data_reg[0];
                    end else begin
                        state_next   = EOP_SE0;
                        eop_cnt_next = '0;
                        line_next    = LINE_SE0;
                        if (!shift_last_reg) begin
                            error_next    = 1'b1;
                            err_seen_next = 1'b1;
                        end
                    end
                end
            end

            EOP_SE0: begin
                if (boundary) begin
                    if (eop_cnt_reg == SE0_LAST) begin
                        state_next  = EOP_J;
                        nrzi_j_next = 1'b1;
                        line_next   = LINE_J;
                    end else begin
                        eop_cnt_next = eop_cnt_reg + EW'(1);
                    end
                end
            end

            EOP_J: begin
                if (boundary) begin
                    state_next  = IDLE;
                    active_next = 1'b0;
                    done_next   = !err_seen_reg;
                    line_next   = LINE_J;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (send_bit) begin
            if (bit_val) begin
                ones_next = (ones_reg == STUFF_MAX) ? ones_reg : ones_reg + OW'(1);
            end else begin
                nrzi_j_next = ~nrzi_j_reg;
                ones_next   = '0;
            end
            line_next = nrzi_j_next ? LINE_J : LINE_K;
        end
    end

endmodule
